// File: rtl/pc_seq.sv
// Fetch PC sequencer with branch/JALR redirect and fixed-length front-end flush.
// Optional branch performance counters are built when PC_SEQ_PERF_CNT_EN is defined.
module pc_seq #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_addr,
   input  logic        br_valid,
   input  logic [1:0]  pc_c,
   input  logic [12:0] b_im,
   input  logic [31:0] br_pc,
   input  logic        jalr_valid,
   input  logic [31:0] jalr_target,
   output logic        flush,
   output logic        misalign,
   output logic [31:0] br_cnt,
   output logic [31:0] taken_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t      state, state_next;
   logic [3:0]  flush_cnt, flush_cnt_next;
   logic [31:0] addr_next;
   logic        misalign_next;

   logic        br_take;
   logic [31:0] br_target;
   logic [31:0] jalr_aligned;
   logic [31:0] redir_target;
   logic        redir_req;

   // The branch outranks a same-cycle JALR; nothing redirects while in IDLE.
   assign br_take      = br_valid && (pc_c == 2'd2);
   assign br_target    = br_pc + {{19{b_im[12]}}, b_im};
   assign jalr_aligned = {jalr_target[31:1], 1'b0};
   assign redir_target = br_take ? br_target : jalr_aligned;
   assign redir_req    = (br_take || jalr_valid) && (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         flush_cnt  <= 4'd0;
         fetch_addr <= RESET_PC;
         misalign   <= 1'b0;
      end else begin
         state      <= state_next;
         flush_cnt  <= flush_cnt_next;
         fetch_addr <= addr_next;
         misalign   <= misalign_next;
      end
   end

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      addr_next      = fetch_addr;
      misalign_next  = 1'b0;
      fetch_valid    = 1'b0;
      flush          = 1'b0;

      case (state)
         IDLE: begin
            state_next = RUN;
         end
         RUN: begin
            fetch_valid = 1'b1;
            if (fetch_ready && !stall) begin
               addr_next = fetch_addr + 32'd4;
            end
         end
         FLUSH: begin
            flush          = 1'b1;
            flush_cnt_next = flush_cnt - 4'd1;
            if (flush_cnt == 4'd1) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A misaligned target is dropped outright: the PC also skips its sequential step.
      if (redir_req) begin
         if (redir_target[1]) begin
            misalign_next = 1'b1;
            addr_next     = fetch_addr;
         end else begin
            addr_next      = redir_target;
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
         end
      end
   end

`ifdef PC_SEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt    <= 32'd0;
         taken_cnt <= 32'd0;
      end else begin
         if (br_valid) begin
            br_cnt <= br_cnt + 32'd1;
         end
         if (br_take) begin
            taken_cnt <= taken_cnt + 32'd1;
         end
      end
   end
`else
   assign br_cnt    = 32'd0;
   assign taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a cycle-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pc_seq;

   localparam logic [31:0] RST_PC    = 32'h0000_0100;
   localparam int          FLUSH_LEN = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_addr;
   logic        br_valid;
   logic [1:0]  pc_c;
   logic [12:0] b_im;
   logic [31:0] br_pc;
   logic        jalr_valid;
   logic [31:0] jalr_target;
   logic        flush;
   logic        misalign;
   logic [31:0] br_cnt;
   logic [31:0] taken_cnt;

   int checks_total  = 0;
   int checks_passed = 0;

   pc_seq #(
      .RESET_PC     (RST_PC),
      .FLUSH_CYCLES (FLUSH_LEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_addr  (fetch_addr),
      .br_valid    (br_valid),
      .pc_c        (pc_c),
      .b_im        (b_im),
      .br_pc       (br_pc),
      .jalr_valid  (jalr_valid),
      .jalr_target (jalr_target),
      .flush       (flush),
      .misalign    (misalign),
      .br_cnt      (br_cnt),
      .taken_cnt   (taken_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: tracks "still in the post-reset idle cycle" and "flush cycles left".
   bit          model_live = 1'b0;
   bit          m_idle;
   int          m_flush_left;
   logic [31:0] m_addr;
   bit          m_mis;
   logic [31:0] m_br;
   logic [31:0] m_taken;

   always @(posedge clk) begin
      bit          take;
      bit          fetching;
      logic [31:0] tgt;
      if (rst) begin
         m_idle       = 1'b1;
         m_flush_left = 0;
         m_addr       = RST_PC;
         m_mis        = 1'b0;
         m_br         = 32'd0;
         m_taken      = 32'd0;
         model_live   = 1'b1;
      end else if (model_live) begin
         take     = br_valid && (pc_c == 2'd2);
         fetching = !m_idle && (m_flush_left == 0);
         tgt      = take ? (br_pc + 32'($signed(b_im))) : (jalr_target & 32'hFFFF_FFFE);
         m_mis    = 1'b0;
         if (m_br != 32'hFFFF_FFFF || !br_valid) m_br = m_br + (br_valid ? 32'd1 : 32'd0);
         else m_br = 32'd0;
         m_taken  = m_taken + (take ? 32'd1 : 32'd0);
         if ((take || jalr_valid) && !m_idle) begin
            if (tgt % 4 == 2 || tgt % 4 == 3) begin
               m_mis = 1'b1;
               if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
            end else begin
               m_addr       = tgt;
               m_flush_left = FLUSH_LEN;
            end
         end else begin
            if (fetching && fetch_ready && !stall) m_addr = m_addr + 32'd4;
            if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
         end
         m_idle = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (model_live) begin
         checkOutput("model.fetch_valid", 32'(fetch_valid), 32'(!m_idle && m_flush_left == 0));
         checkOutput("model.flush", 32'(flush), 32'(m_flush_left > 0));
         checkOutput("model.misalign", 32'(misalign), 32'(m_mis));
         checkOutput("model.fetch_addr", fetch_addr, m_addr);
`ifdef PC_SEQ_PERF_CNT_EN
         checkOutput("model.br_cnt", br_cnt, m_br);
         checkOutput("model.taken_cnt", taken_cnt, m_taken);
`else
         checkOutput("model.br_cnt", br_cnt, 32'd0);
         checkOutput("model.taken_cnt", taken_cnt, 32'd0);
`endif
      end
   end

   task automatic applyStimulus(input logic r, input logic fr, input logic st,
                                input logic bv, input logic [1:0] code,
                                input logic [12:0] imm, input logic [31:0] bpc,
                                input logic jv, input logic [31:0] jt);
      rst         = r;
      fetch_ready = fr;
      stall       = st;
      br_valid    = bv;
      pc_c        = code;
      b_im        = imm;
      br_pc       = bpc;
      jalr_valid  = jv;
      jalr_target = jt;
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
      br_valid = 1'b0; pc_c = 2'd0; b_im = 13'h0; br_pc = 32'h0;
      jalr_valid = 1'b0; jalr_target = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset.fetch_valid", 32'(fetch_valid), 32'd0);
      checkOutput("reset.fetch_addr", fetch_addr, 32'h100);
      checkOutput("reset.flush", 32'(flush), 32'd0);
      checkOutput("reset.misalign", 32'(misalign), 32'd0);

      // Release reset: one idle cycle, then sequential fetch.
      idleCycle();
      checkOutput("seq.valid_up", 32'(fetch_valid), 32'd1);
      checkOutput("seq.addr0", fetch_addr, 32'h100);
      idleCycle();
      checkOutput("seq.addr1", fetch_addr, 32'h104);
      idleCycle();
      checkOutput("seq.addr2", fetch_addr, 32'h108);

      // Backpressure, then stall, then release.
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("bp.hold", fetch_addr, 32'h108);
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 13'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("stall.hold", fetch_addr, 32'h108);
      idleCycle();
      checkOutput("release.addr", fetch_addr, 32'h10C);

      // Backward taken branch: 0x200 - 8.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 13'h1FF8, 32'h200, 1'b0, 32'h0);
      checkOutput("bbr.addr", fetch_addr, 32'h1F8);
      checkOutput("bbr.flush1", 32'(flush), 32'd1);
      checkOutput("bbr.valid_low", 32'(fetch_valid), 32'd0);
      idleCycle();
      checkOutput("bbr.flush2", 32'(flush), 32'd1);
      idleCycle();
      checkOutput("bbr.flush_end", 32'(flush), 32'd0);
      checkOutput("bbr.valid_back", 32'(fetch_valid), 32'd1);
      idleCycle();
      checkOutput("bbr.advance", fetch_addr, 32'h1FC);

      // Branch and JALR together, then JALR re-redirect during the flush.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 13'h0080, 32'h280, 1'b1, 32'h500);
      checkOutput("both.branch_wins", fetch_addr, 32'h300);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 32'h0, 1'b1, 32'h401);
      checkOutput("reredir.addr", fetch_addr, 32'h400);
      idleCycle();
      checkOutput("reredir.flush_restart", 32'(flush), 32'd1);
      idleCycle();
      checkOutput("reredir.valid_back", 32'(fetch_valid), 32'd1);

      // Misaligned JALR is dropped.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 32'h0, 1'b1, 32'h402);
      checkOutput("mis.pulse", 32'(misalign), 32'd1);
      checkOutput("mis.no_flush", 32'(flush), 32'd0);
      checkOutput("mis.pc_held", fetch_addr, 32'h400);
      idleCycle();
      checkOutput("mis.pulse_end", 32'(misalign), 32'd0);
      checkOutput("mis.resume", fetch_addr, 32'h404);

      // Jump to the top of the address space and wrap.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 32'h0, 1'b1, 32'hFFFF_FFFD);
      checkOutput("wrap.top", fetch_addr, 32'hFFFF_FFFC);
      repeat (2) idleCycle();
      checkOutput("wrap.top_valid", 32'(fetch_valid), 32'd1);
      idleCycle();
      checkOutput("wrap.zero", fetch_addr, 32'h0);

      // Reset in the middle of a flush.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 13'h0040, 32'h0, 1'b0, 32'h0);
      checkOutput("midflush.flush", 32'(flush), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("midflush.rst_addr", fetch_addr, 32'h100);
      checkOutput("midflush.rst_flush", 32'(flush), 32'd0);
      checkOutput("midflush.rst_valid", 32'(fetch_valid), 32'd0);
      checkOutput("midflush.rst_brcnt", br_cnt, 32'd0);

      // Five br_valid cycles, two taken (the first lands in IDLE and is ignored).
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 13'h0010, 32'h100, 1'b0, 32'h0);
      checkOutput("cnt.idle_ignored", fetch_addr, 32'h100);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 13'h0010, 32'h100, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 13'h0010, 32'h100, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 13'h0020, 32'h108, 1'b0, 32'h0);
      checkOutput("cnt.taken_target", fetch_addr, 32'h128);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 13'h0010, 32'h100, 1'b0, 32'h0);
      idleCycle();
`ifdef PC_SEQ_PERF_CNT_EN
      checkOutput("cnt.br_cnt", br_cnt, 32'd5);
      checkOutput("cnt.taken_cnt", taken_cnt, 32'd2);
`else
      checkOutput("cnt.br_cnt", br_cnt, 32'd0);
      checkOutput("cnt.taken_cnt", taken_cnt, 32'd0);
`endif
      repeat (4) idleCycle();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
